matrix_key_scan: RTL and testbench

MATRIX_KEY_SCAN -- requirements
Module: matrix_key_scan

---
 rtl/digital_clock_pkg.sv | 25 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/matrix_key_scan.sv | 128 ++++++++++++
 tb/tb_matrix_key_scan.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/digital_clock_pkg.sv
// Shared types and constants for the keypad scanner.
// KEY_REPEAT_EN (optional) enables auto-repeat in matrix_key_scan.
package digital_clock_pkg;

    typedef enum logic [1:0] {
        SCAN,
        PRESS_DEB,
        HELD,
        REL_DEB
    } scan_state_t;

    localparam int KEY_W = 4;
    localparam logic [3:0] COL_RST = 4'b1110;

    // Lowest-index row reading 0; callers guarantee at least one is low
    function automatic logic [1:0] low_row(input logic [3:0] r);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!r[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, width-parameterized.
// Independent of KEY_REPEAT_EN.
module sync_2ff #(
    parameter int W = 4,
    parameter logic [W-1:0] RST_VAL = '1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/matrix_key_scan.sv
// 4x4 keypad scanner with press/release debounce.
// Define KEY_REPEAT_EN to add auto-repeat while a key is held.
import digital_clock_pkg::*;

module matrix_key_scan #(
    parameter int SCAN_CYC = 50000,
    parameter int DEB_CYC  = 500000,
    parameter int REP_CYC  = 25000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       row_in,
    output logic [3:0]       col_out,
    output logic             key_vaild,
    output logic [KEY_W-1:0] key_code
);

`ifdef KEY_REPEAT_EN
    localparam int MAX_SD  = SCAN_CYC > DEB_CYC ? SCAN_CYC : DEB_CYC;
    localparam int MAX_CYC = MAX_SD > REP_CYC ? MAX_SD : REP_CYC;
`else
    localparam int MAX_CYC = SCAN_CYC > DEB_CYC ? SCAN_CYC : DEB_CYC;
`endif
    localparam int CW = MAX_CYC > 1 ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYC - 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYC - 1);
`ifdef KEY_REPEAT_EN
    localparam logic [CW-1:0] REP_LAST  = CW'(REP_CYC - 1);
`endif

    logic [3:0]  row_s;
    scan_state_t state;
    logic [CW-1:0] cnt;
    logic [1:0]  col_idx;
    logic [1:0]  row_idx;
`ifdef KEY_REPEAT_EN
    logic [CW-1:0] rep_cnt;
`endif

    sync_2ff #(
        .W       (4),
        .RST_VAL (4'hF)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (row_in),
        .q       (row_s)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= SCAN;
            cnt       <= '0;
            col_idx   <= 2'd0;
            row_idx   <= 2'd0;
            col_out   <= COL_RST;
            key_vaild <= 1'b0;
            key_code  <= '0;
`ifdef KEY_REPEAT_EN
            rep_cnt   <= '0;
`endif
        end else begin
            key_vaild <= 1'b0;
            unique case (state)
                SCAN: begin
                    if (cnt == SCAN_LAST) begin
                        cnt <= '0;
                        if (row_s != 4'hF) begin
                            row_idx <= low_row(row_s);
                            state   <= PRESS_DEB;
                        end else begin
                            col_idx <= col_idx + 2'd1;
                            col_out <= {col_out[2:0], col_out[3]};
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESS_DEB: begin
                    if (row_s[row_idx]) begin
                        state   <= SCAN;
                        cnt     <= '0;
                        col_idx <= col_idx + 2'd1;
                        col_out <= {col_out[2:0], col_out[3]};
                    end else if (cnt == DEB_LAST) begin
                        key_vaild <= 1'b1;
                        key_code  <= {row_idx, col_idx};
                        state     <= HELD;
`ifdef KEY_REPEAT_EN
                        rep_cnt   <= '0;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (row_s[row_idx]) begin
                        state <= REL_DEB;
                        cnt   <= '0;
`ifdef KEY_REPEAT_EN
                        rep_cnt <= '0;
                    end else if (rep_cnt == REP_LAST) begin
                        key_vaild <= 1'b1;
                        rep_cnt   <= '0;
                    end else begin
                        rep_cnt <= rep_cnt + 1'b1;
`endif
                    end
                end
                REL_DEB: begin
                    // a bounce back to 0 resumes the hold without a pulse
                    if (!row_s[row_idx]) begin
                        state <= HELD;
                    end else if (cnt == DEB_LAST) begin
                        state   <= SCAN;
                        cnt     <= '0;
                        col_idx <= col_idx + 2'd1;
                        col_out <= {col_out[2:0], col_out[3]};
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_key_scan.sv
// Bench for matrix_key_scan: directed and random keypad activity checked
// against a run-length reference model (honours KEY_REPEAT_EN).
`timescale 1ns/1ps
module tb_matrix_key_scan;

    localparam int SCAN = 4;
    localparam int DEB  = 8;
    localparam int REP  = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic key_vaild;
    logic [15:0] keys = '0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pulses = 0;
    int ptimes[$];

    always #5 clk = ~clk;

    // physical keypad: a pressed key pulls its row low while its column is driven
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && col_out[c] == 1'b0) row_in[r] = 1'b0;
    end

    matrix_key_scan #(
        .SCAN_CYC (SCAN),
        .DEB_CYC  (DEB),
        .REP_CYC  (REP)
    ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_vaild (key_vaild),
        .key_code  (key_code)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    // reference model: phase 0 sweeping, 1 confirming press,
    // 2 key down, 3 confirming release
    int m_phase, m_col, m_dwell, m_row, m_run, m_since;
    logic [3:0] m_p1, m_p2, m_code;
    bit m_pulse;

    function automatic int lowest(input logic [3:0] r);
        for (int i = 0; i < 4; i++) if (!r[i]) return i;
        return 0;
    endfunction

    task automatic m_reset();
        m_phase = 0; m_col = 0; m_dwell = 0; m_row = 0;
        m_run = 0; m_since = 0; m_p1 = 4'hF; m_p2 = 4'hF;
        m_code = 4'd0; m_pulse = 1'b0;
    endtask

    task automatic step(input logic rst_n, input logic [3:0] r);
        logic [3:0] rs;
        m_pulse = 1'b0;
        if (!rst_n) begin
            m_reset();
            return;
        end
        rs = m_p2;
        m_p2 = m_p1;
        m_p1 = r;
        case (m_phase)
            0: begin
                m_dwell++;
                if (m_dwell == SCAN) begin
                    m_dwell = 0;
                    if (rs != 4'hF) begin
                        m_row = lowest(rs);
                        m_run = 1;
                        m_phase = 1;
                    end else m_col = (m_col + 1) % 4;
                end
            end
            1: begin
                if (rs[m_row]) begin
                    m_phase = 0; m_col = (m_col + 1) % 4; m_dwell = 0;
                end else begin
                    m_run++;
                    if (m_run == DEB + 1) begin
                        m_pulse = 1'b1;
                        m_code = 4'(4 * m_row + m_col);
                        m_phase = 2;
                        m_since = 0;
                    end
                end
            end
            2: begin
                if (rs[m_row]) begin
                    m_phase = 3; m_run = 1; m_since = 0;
                end else begin
`ifdef KEY_REPEAT_EN
                    m_since++;
                    if (m_since == REP) begin
                        m_pulse = 1'b1;
                        m_since = 0;
                    end
`endif
                end
            end
            default: begin
                if (!rs[m_row]) m_phase = 2;
                else begin
                    m_run++;
                    if (m_run == DEB + 1) begin
                        m_phase = 0; m_col = (m_col + 1) % 4; m_dwell = 0;
                    end
                end
            end
        endcase
    endtask

    initial begin
        logic [3:0] ec;
        m_reset();
        forever begin
            @(posedge clk);
            cyc++;
            step(reset_n, row_in);
            #1;
            ec = ~(4'b0001 << m_col);
            check("col_out", col_out, ec);
            check("key_vaild", key_vaild, m_pulse);
            check("key_code", key_code, m_code);
            if (key_vaild === 1'b1) begin
                pulses++;
                ptimes.push_back(cyc);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // wait until col_out newly switches to v
    task automatic wait_col(input logic [3:0] v, input string tag);
        int n = 0;
        while (col_out === v && n < 200) begin @(negedge clk); n++; end
        while (col_out !== v && n < 200) begin @(negedge clk); n++; end
        if (col_out !== v) check(tag, col_out, v);
    endtask

    task automatic wait_pulse(input int p0, input string tag);
        int n = 0;
        while (pulses == p0 && n < 300) begin @(negedge clk); n++; end
        if (pulses == p0) check(tag, pulses, p0 + 1);
    endtask

    initial begin
        int p0, k, first, exp_n;
        logic [3:0] c0;
        bit moved;

        reset_n = 1'b0;
        idle(5);
        check("rst_col", col_out, 4'b1110);
        check("rst_vld", key_vaild, 1'b0);
        check("rst_code", key_code, 4'd0);
        reset_n = 1'b1;

        // clean press on row 1, col 2
        wait_col(4'b1011, "to_col2");
        p0 = pulses;
        keys[6] = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (pulses > p0) check("frozen_col2", col_out, 4'b1011);
        end
        keys[6] = 1'b0;
        check("press_code", key_code, 4'd6);
        idle(20);
        check("press_cnt", pulses - p0, 1);

        // bouncing row 0 never settles
        wait_col(4'b1110, "to_col0");
        p0 = pulses;
        repeat (5) begin
            keys[0] = 1'b1; idle(3);
            keys[0] = 1'b0; idle(2);
        end
        idle(10);
        check("bounce_cnt", pulses - p0, 0);
        c0 = col_out;
        moved = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (col_out !== c0) moved = 1'b1;
        end
        check("bounce_scan", moved, 1'b1);

        // rows 0 and 3 together on col 3
        wait_col(4'b0111, "to_col3");
        p0 = pulses;
        keys[3] = 1'b1;
        keys[15] = 1'b1;
        idle(30);
        keys = '0;
        idle(20);
        check("multi_cnt", pulses - p0, 1);
        check("multi_code", key_code, 4'd3);

        // hold with a one-cycle release glitch, then key 8
        wait_col(4'b1011, "to_col2b");
        p0 = pulses;
        keys[10] = 1'b1; idle(16);
        keys[10] = 1'b0; idle(1);
        keys[10] = 1'b1; idle(8);
        keys[10] = 1'b0; idle(20);
        check("glitch_cnt", pulses - p0, 1);
        check("glitch_code", key_code, 4'd10);
        wait_col(4'b1110, "to_col0b");
        p0 = pulses;
        keys[8] = 1'b1; idle(16);
        keys[8] = 1'b0; idle(20);
        check("rel_cnt", pulses - p0, 1);
        check("rel_code", key_code, 4'd8);

        // long hold on key 5
        wait_col(4'b1101, "to_col1");
        p0 = pulses;
        keys[5] = 1'b1;
        wait_pulse(p0, "rep_first");
        idle(99);
        keys[5] = 1'b0;
        idle(20);
`ifdef KEY_REPEAT_EN
        exp_n = 4;
`else
        exp_n = 1;
`endif
        check("rep_cnt", pulses - p0, exp_n);
        check("rep_code", key_code, 4'd5);
        if (pulses - p0 == exp_n) begin
            first = ptimes[p0];
            for (int i = 1; i < exp_n; i++)
                check("rep_time", ptimes[p0+i] - first, REP * i);
        end

        // reset in the middle of press debounce
        wait_col(4'b1110, "to_col0c");
        p0 = pulses;
        keys[0] = 1'b1;
        idle(7);
        reset_n = 1'b0;
        idle(2);
        keys[0] = 1'b0;
        idle(3);
        check("mid_rst_col", col_out, 4'b1110);
        check("mid_rst_vld", key_vaild, 1'b0);
        check("mid_rst_code", key_code, 4'd0);
        reset_n = 1'b1;
        idle(30);
        check("mid_rst_cnt", pulses - p0, 0);

        // random activity; the model checks every cycle
        repeat (60) begin
            k = $urandom_range(0, 15);
            case ($urandom_range(0, 3))
                0: begin
                    keys[k] = 1'b1; idle($urandom_range(20, 60));
                    keys[k] = 1'b0;
                end
                1: begin
                    keys[k] = 1'b1; idle($urandom_range(1, 6));
                    keys[k] = 1'b0;
                end
                2: begin
                    keys[k] = 1'b1;
                    keys[$urandom_range(0, 15)] = 1'b1;
                    idle($urandom_range(10, 50));
                    keys = '0;
                end
                default: begin
                    repeat ($urandom_range(3, 12)) begin
                        keys[k] = ~keys[k];
                        idle($urandom_range(1, 12));
                    end
                    keys[k] = 1'b0;
                end
            endcase
            idle($urandom_range(0, 25));
        end
        keys = '0;
        idle(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
